// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: instruction classes, opcodes,
// fetch FSM states and the IF->ID bundle.
package if_stage_pkg;

    typedef enum logic [3:0] {
        INST_TYPE_NONE   = 4'd0,
        INST_TYPE_ALU    = 4'd1,
        INST_TYPE_IMM    = 4'd2,
        INST_TYPE_LOAD   = 4'd3,
        INST_TYPE_STORE  = 4'd4,
        INST_TYPE_BRANCH = 4'd5,
        INST_TYPE_JUMP   = 4'd6
    } inst_type_e;

    localparam logic [5:0] OP_ALU = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    // opcodes 8..15 share this upper field
    localparam logic [2:0] OP_IMM_HI = 3'b001;

    typedef enum logic {
        S_FETCH,
        S_SQUASH
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        inst_type_e  itype;
        logic [3:0]  num;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between IF and imem.
// A request completes on the cycle where req and ready are both high.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/inst_classify.sv
// Combinational opcode-class decoder, shared by IF and ID.
// Maps the 6-bit major opcode onto an inst_type_e class.
module inst_classify
    import if_stage_pkg::*;
(
    input  logic [5:0] op,
    output inst_type_e itype
);

    always_comb begin
        itype = INST_TYPE_NONE;
        unique case (1'b1)
            (op == OP_ALU):               itype = INST_TYPE_ALU;
            (op[5:3] == OP_IMM_HI):       itype = INST_TYPE_IMM;
            (op == OP_LW):                itype = INST_TYPE_LOAD;
            (op == OP_SW):                itype = INST_TYPE_STORE;
            (op == OP_BEQ || op == OP_BNE): itype = INST_TYPE_BRANCH;
            (op == OP_J || op == OP_JAL): itype = INST_TYPE_JUMP;
            default:                      itype = INST_TYPE_NONE;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: pc, one-entry buffer toward ID, and a
// FETCH/SQUASH FSM that drains a request orphaned by a redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        id_redirect,
    input  logic [31:0] id_new_pc,
    if_stage_if.master  imem,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);

    fetch_state_e state, state_nx;
    logic [31:0]  pc;
    logic [31:0]  sq_addr;
    logic         pend;
    logic [3:0]   seq;
    if_id_t       fb;

    logic         req;
    logic [31:0]  addr;
    logic         accept;
    logic         fire;
    logic         capture;
    inst_type_e   rd_type;

    inst_classify u_classify (
        .op    (imem.imem_rdata[31:26]),
        .itype (rd_type)
    );

    assign accept = fb.valid & ~id_stall;

    // pend keeps an issued request alive until ready, whatever ID does
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        addr     = pc;
        unique case (state)
            S_FETCH: begin
                req = pend |
                      ((~fb.valid | accept) & ~id_redirect);
                if (id_redirect & req & ~imem.imem_ready)
                    state_nx = S_SQUASH;
            end
            S_SQUASH: begin
                req  = 1'b1;
                addr = sq_addr;
                if (imem.imem_ready)
                    state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
        if (rst)
            req = 1'b0;
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    assign fire    = req & imem.imem_ready;
    assign capture = fire & (state == S_FETCH) & ~id_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            sq_addr <= RESET_PC;
            pend    <= 1'b0;
            seq     <= 4'd0;
            fb      <= '0;
        end else begin
            state <= state_nx;
            pend  <= req & ~imem.imem_ready;
            if (state == S_FETCH && state_nx == S_SQUASH)
                sq_addr <= pc;
            if (id_redirect)
                pc <= id_new_pc;
            else if (capture)
                pc <= pc + 32'd4;
            if (capture)
                seq <= seq + 4'd1;
            if (capture)
                fb <= '{inst:  imem.imem_rdata,
                        pc4:   pc + 32'd4,
                        itype: rd_type,
                        num:   seq,
                        valid: 1'b1};
            else if (id_redirect | accept)
                fb <= '0;
        end
    end

    assign if_inst       = fb.inst;
    assign if_pc4        = fb.pc4;
    assign IF_ins_type   = fb.itype;
    assign IF_ins_number = fb.num;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch scenarios plus a randomized
// run scored against an in-order program-stream model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        id_redirect;
    logic [31:0] id_new_pc;
    logic        rdy;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;

    int checks = 0;
    int errors = 0;

    if_stage_if imem ();

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_stall      (id_stall),
        .id_redirect   (id_redirect),
        .id_new_pc     (id_new_pc),
        .imem          (imem),
        .if_inst       (if_inst),
        .if_pc4        (if_pc4),
        .IF_ins_type   (IF_ins_type),
        .IF_ins_number (IF_ins_number)
    );

    always #5 clk = ~clk;

    // memory image: fixed word at 0, never-zero pseudo-random elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [5:0]  op;
        if (a == 32'h0) return 32'h2001_0005;
        h = (a ^ 32'h1234_5677) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        case (h[3:1])
            3'd0: op = 6'd0;
            3'd1: op = 6'd9;
            3'd2: op = 6'd35;
            3'd3: op = 6'd43;
            3'd4: op = 6'd4;
            3'd5: op = 6'd2;
            3'd6: op = 6'd17;
            default: op = 6'd63;
        endcase
        return {op, h[25:1], 1'b1};
    endfunction

    function automatic logic [3:0] exp_type(input logic [31:0] w);
        int op;
        op = int'(w[31:26]);
        if (op == 0) return INST_TYPE_ALU;
        if (op >= 8 && op <= 15) return INST_TYPE_IMM;
        if (op == 35) return INST_TYPE_LOAD;
        if (op == 43) return INST_TYPE_STORE;
        if (op == 4 || op == 5) return INST_TYPE_BRANCH;
        if (op == 2 || op == 3) return INST_TYPE_JUMP;
        return INST_TYPE_NONE;
    endfunction

    assign imem.imem_ready = rdy;
    assign imem.imem_rdata = mem_word(imem.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_stall = 1'b0;
        id_redirect = 1'b0;
        id_new_pc = 32'h0;
        rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_stall = 1'b0;
        id_redirect = 1'b0;
        id_new_pc = 32'h0;
        rdy = 1'b1;
        tick();
        checks++;
        if (imem.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b exp 0", imem.imem_req);
        end
        checks++;
        if ({if_inst, if_pc4, IF_ins_type, IF_ins_number} !== 72'h0) begin
            errors++;
            $display("FAIL rst_out got %h/%h/%h/%h exp 0/0/0/0",
                     if_inst, if_pc4, IF_ins_type, IF_ins_number);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req got %b@%h exp 1@0",
                     imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_first_fetch();
        tick();
        checks++;
        if (if_inst !== 32'h2001_0005 || if_pc4 !== 32'd4) begin
            errors++;
            $display("FAIL first_inst got %h/%h exp 20010005/4",
                     if_inst, if_pc4);
        end
        checks++;
        if (IF_ins_type !== INST_TYPE_IMM || IF_ins_number !== 4'd0) begin
            errors++;
            $display("FAIL first_meta got %0d/%0d exp %0d/0",
                     IF_ins_type, IF_ins_number, INST_TYPE_IMM);
        end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_req got %b exp 0", imem.imem_req);
            end
            tick();
            checks++;
            if (if_inst !== 32'h2001_0005 || IF_ins_number !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold got %h/%0d exp 20010005/0",
                         if_inst, IF_ins_number);
            end
        end
        id_stall = 1'b0;
        #1;
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd4) begin
            errors++;
            $display("FAIL stall_rel got %b@%h exp 1@4",
                     imem.imem_req, imem.imem_addr);
        end
        tick();
        checks++;
        if (if_inst !== mem_word(32'd4) || if_pc4 !== 32'd8 ||
            IF_ins_number !== 4'd1 ||
            IF_ins_type !== exp_type(mem_word(32'd4))) begin
            errors++;
            $display("FAIL stall_next got %h/%h/%0d exp %h/8/1",
                     if_inst, if_pc4, IF_ins_number, mem_word(32'd4));
        end
    endtask

    task automatic test_wait_state();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rdy = 1'b1;
            #1;
            checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd8) begin
                errors++;
                $display("FAIL wait_addr cyc %0d got %b@%h exp 1@8",
                         i, imem.imem_req, imem.imem_addr);
            end
            tick();
            if (i < 3) begin
                checks++;
                if (if_inst !== 32'h0) begin
                    errors++;
                    $display("FAIL wait_empty got %h exp 0", if_inst);
                end
            end
        end
        checks++;
        if (if_inst !== mem_word(32'd8) || if_pc4 !== 32'd12 ||
            IF_ins_number !== 4'd2) begin
            errors++;
            $display("FAIL wait_cap got %h/%h/%0d exp %h/c/2",
                     if_inst, if_pc4, IF_ins_number, mem_word(32'd8));
        end
    endtask

    task automatic test_squash();
        tick();
        checks++;
        if (if_inst !== mem_word(32'hC) || IF_ins_number !== 4'd3) begin
            errors++;
            $display("FAIL sq_pre got %h/%0d exp %h/3",
                     if_inst, IF_ins_number, mem_word(32'hC));
        end
        rdy = 1'b0;
        tick();
        id_redirect = 1'b1;
        id_new_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) id_new_pc = 32'h40;
            if (i == 2) begin
                id_redirect = 1'b0;
                rdy = 1'b1;
            end
            #1;
            checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h10) begin
                errors++;
                $display("FAIL sq_hold cyc %0d got %b@%h exp 1@10",
                         i, imem.imem_req, imem.imem_addr);
            end
            tick();
            checks++;
            if (if_inst !== 32'h0) begin
                errors++;
                $display("FAIL sq_discard got %h exp 0", if_inst);
            end
        end
        #1;
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL sq_target got %b@%h exp 1@40",
                     imem.imem_req, imem.imem_addr);
        end
        tick();
        checks++;
        if (if_inst !== mem_word(32'h40) || if_pc4 !== 32'h44 ||
            IF_ins_number !== 4'd4) begin
            errors++;
            $display("FAIL sq_next got %h/%h/%0d exp %h/44/4",
                     if_inst, if_pc4, IF_ins_number, mem_word(32'h40));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        do_reset();
        id_redirect = 1'b1;
        id_new_pc = 32'hFFFF_FFC0;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_noreq got %b exp 0", imem.imem_req);
        end
        tick();
        id_redirect = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a = 32'hFFFF_FFC0 + 32'(4 * i);
            #1;
            checks++;
            if (imem.imem_addr !== a) begin
                errors++;
                $display("FAIL wrap_addr %0d got %h exp %h",
                         i, imem.imem_addr, a);
            end
            tick();
            checks++;
            if (if_inst !== mem_word(a) || if_pc4 !== a + 32'd4 ||
                IF_ins_number !== 4'(i)) begin
                errors++;
                $display("FAIL wrap_inst %0d got %h/%h/%0d exp %h/%h/%0d",
                         i, if_inst, if_pc4, IF_ins_number,
                         mem_word(a), a + 32'd4, i % 16);
            end
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b1;
        tick();
        checks++;
        if (if_inst !== mem_word(32'd4)) begin
            errors++;
            $display("FAIL rm_pre got %h exp %h", if_inst, mem_word(32'd4));
        end
        rdy = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0 ||
            {if_inst, if_pc4, IF_ins_type, IF_ins_number} !== 72'h0) begin
            errors++;
            $display("FAIL rm_clear got %b %h/%h/%h/%h exp 0 0/0/0/0",
                     imem.imem_req, if_inst, if_pc4,
                     IF_ins_type, IF_ins_number);
        end
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rm_restart got %b@%h exp 1@0",
                     imem.imem_req, imem.imem_addr);
        end
        tick();
        checks++;
        if (if_inst !== 32'h2001_0005 || IF_ins_number !== 4'd0) begin
            errors++;
            $display("FAIL rm_first got %h/%0d exp 20010005/0",
                     if_inst, IF_ins_number);
        end
    endtask

    // model: ID sees the program in order from the last redirect target;
    // a buffered instruction dropped by a redirect still used a number
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [3:0]  exp_seq;
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic [31:0] np;
        logic        valid;
        int          accepts;
        do_reset();
        exp_pc = 32'h0;
        exp_seq = 4'd0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        accepts = 0;
        for (int c = 0; c < 2000; c++) begin
            np = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 3 == 0) np = 32'hFFFF_FFF0 | (np & 32'hC);
            id_stall = ($urandom % 4 == 0);
            id_redirect = ($urandom % 20 == 0);
            id_new_pc = np;
            rdy = ($urandom % 3 != 0);
            #1;
            if (prev_pend) begin
                checks++;
                if (imem.imem_req !== 1'b1 || imem.imem_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_hold cyc %0d got %b@%h exp 1@%h",
                             c, imem.imem_req, imem.imem_addr, prev_addr);
                end
            end
            valid = (if_inst != 32'h0);
            if (!valid) begin
                checks++;
                if ({if_pc4, IF_ins_type, IF_ins_number} !== 40'h0) begin
                    errors++;
                    $display("FAIL rnd_nop cyc %0d got %h/%h/%h exp 0/0/0",
                             c, if_pc4, IF_ins_type, IF_ins_number);
                end
            end
            if (id_redirect) begin
                if (valid) exp_seq = exp_seq + 4'd1;
                exp_pc = np;
            end else if (valid && !id_stall) begin
                checks++;
                if (if_inst !== mem_word(exp_pc) ||
                    if_pc4 !== exp_pc + 32'd4 ||
                    IF_ins_type !== exp_type(mem_word(exp_pc)) ||
                    IF_ins_number !== exp_seq) begin
                    errors++;
                    $display("FAIL rnd_inst cyc %0d got %h/%h/%0d/%0d exp %h/%h/%0d/%0d",
                             c, if_inst, if_pc4, IF_ins_type, IF_ins_number,
                             mem_word(exp_pc), exp_pc + 32'd4,
                             exp_type(mem_word(exp_pc)), exp_seq);
                end
                exp_pc = exp_pc + 32'd4;
                exp_seq = exp_seq + 4'd1;
                accepts++;
            end
            prev_pend = imem.imem_req & ~rdy;
            prev_addr = imem.imem_addr;
            tick();
        end
        checks++;
        if (accepts < 400) begin
            errors++;
            $display("FAIL rnd_progress got %0d accepts exp >= 400", accepts);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_wait_state();
        test_squash();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
